mrelbp_ci_frame_sched: RTL

MRELBP_CI_FRAME_SCHED -- requirements
Module: mrelbp_ci_frame_sched

---
 rtl/mrelbp_pkg.sv | 22 ++
 rtl/mrelbp_raster_cnt.sv | 43 ++++
 rtl/mrelbp_ci_frame_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mrelbp_pkg.sv
// Shared definitions for the MRELBP CI frame scheduler.
// Holds the FSM state encoding, the error-code values and the default
// sampling radius of the CI datapath.
package mrelbp_pkg;

   localparam int unsigned DEFAULT_RADIUS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_SIZE     = 2'b01,
      ERR_TIMEOUT  = 2'b10,
      ERR_SPURIOUS = 2'b11
   } err_code_t;

endpackage

// File: rtl/mrelbp_raster_cnt.sv
// Raster-order column/row position counter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         return position to (0,0)
//   adv           advance one pixel in raster order
//   width, height latched frame dimensions
//   col, row      current pixel position (registered)
//   last_c        current position is the final pixel of the frame
module mrelbp_raster_cnt #(
   parameter int unsigned DIM_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             adv,
   input  logic [DIM_W-1:0] width,
   input  logic [DIM_W-1:0] height,
   output logic [DIM_W-1:0] col,
   output logic [DIM_W-1:0] row,
   output logic             last_c
);

   logic col_end_c;

   assign col_end_c = (col == width - DIM_W'(1));
   assign last_c    = col_end_c && (row == height - DIM_W'(1));

   // Column wraps at the end of a line and carries into the row.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         col <= '0;
         row <= '0;
      end else if (adv) begin
         if (col_end_c) begin
            col <= '0;
            row <= last_c ? '0 : row + DIM_W'(1);
         end else begin
            col <= col + DIM_W'(1);
         end
      end
   end

endmodule

// File: rtl/mrelbp_ci_frame_sched.sv
// Frame scheduler for the MRELBP CI datapath: walks a raster frame, issues
// one CI request per interior pixel (RADIUS margin on every side), tracks
// returned results, detects bad frame sizes, drain timeouts and spurious
// returns.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i, width_i/height_i frame start request and dimensions
//   pix_valid_i              one raster pixel presented
//   ci_done_o                issue strobe to CI datapath
//   ci_valid_i, ci_bit_i     CI result return and its bit
//   busy_o, frame_done_o     status / completion pulse
//   err_o, err_code_o        error pulse and code
//   hist_ones_o/hist_total_o CI statistics (only with MRELBP_CI_HIST_EN)
// Optional feature macro: MRELBP_CI_HIST_EN
module mrelbp_ci_frame_sched
   import mrelbp_pkg::*;
#(
   parameter int unsigned DIM_W   = 10,
   parameter int unsigned RADIUS  = DEFAULT_RADIUS,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [DIM_W-1:0]   width_i,
   input  logic [DIM_W-1:0]   height_i,
   input  logic               pix_valid_i,
   output logic               ci_done_o,
   input  logic               ci_valid_i,
   input  logic               ci_bit_i,
   output logic               busy_o,
   output logic               frame_done_o,
   output logic               err_o,
`ifdef MRELBP_CI_HIST_EN
   output logic [2*DIM_W-1:0] hist_ones_o,
   output logic [2*DIM_W-1:0] hist_total_o,
`endif
   output logic [1:0]         err_code_o
);

   localparam int unsigned CNT_W = 2*DIM_W;
   localparam int unsigned TMO_W = $clog2(TIMEOUT+1);
   localparam logic [DIM_W-1:0] MIN_DIM = DIM_W'(2*RADIUS+1);
   localparam logic [DIM_W-1:0] MARGIN  = DIM_W'(2*RADIUS);

   state_t           state;
   logic [DIM_W-1:0] width_q;
   logic [DIM_W-1:0] height_q;
   logic [DIM_W-1:0] col;
   logic [DIM_W-1:0] row;
   logic             last_c;
   logic [CNT_W-1:0] issued;
   logic [CNT_W-1:0] returned;
   logic [TMO_W-1:0] tmo_cnt;

   logic pix_c;
   logic start_ok_c;
   logic issue_c;
   logic spurious_c;
   logic ret_c;
   logic drain_done_c;

   assign pix_c        = pix_valid_i && (state == ST_RUN);
   assign start_ok_c   = start_i && (state == ST_IDLE) &&
                         (width_i >= MIN_DIM) && (height_i >= MIN_DIM);
   assign issue_c      = pix_c && (row >= MARGIN) && (col >= MARGIN);
   // A return with nothing outstanding is an error and is not counted.
   assign spurious_c   = ci_valid_i && (returned == issued);
   assign ret_c        = ci_valid_i && !spurious_c &&
                         ((state == ST_RUN) || (state == ST_DRAIN));
   assign drain_done_c = ret_c && ((returned + CNT_W'(1)) == issued);

   mrelbp_raster_cnt #(
      .DIM_W (DIM_W)
   ) u_raster (
      .clk    (clk),
      .rst    (rst),
      .clear  (start_ok_c),
      .adv    (pix_c),
      .width  (width_q),
      .height (height_q),
      .col    (col),
      .row    (row),
      .last_c (last_c)
   );

   // Frame FSM with registered status/strobe outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         width_q      <= '0;
         height_q     <= '0;
         issued       <= '0;
         returned     <= '0;
         tmo_cnt      <= '0;
         ci_done_o    <= 1'b0;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
         err_o        <= 1'b0;
         err_code_o   <= ERR_NONE;
      end else begin
         ci_done_o    <= issue_c;
         frame_done_o <= 1'b0;
         err_o        <= 1'b0;
         err_code_o   <= ERR_NONE;

         if (issue_c) issued   <= issued + CNT_W'(1);
         if (ret_c)   returned <= returned + CNT_W'(1);

         if (spurious_c) begin
            err_o      <= 1'b1;
            err_code_o <= ERR_SPURIOUS;
         end

         unique case (state)
            ST_IDLE: begin
               if (start_ok_c) begin
                  width_q  <= width_i;
                  height_q <= height_i;
                  issued   <= '0;
                  returned <= '0;
                  busy_o   <= 1'b1;
                  state    <= ST_RUN;
               end else if (start_i) begin
                  err_o      <= 1'b1;
                  err_code_o <= ERR_SIZE;
               end
            end
            ST_RUN: begin
               if (pix_c && last_c) begin
                  tmo_cnt <= '0;
                  state   <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (drain_done_c) begin
                  state <= ST_DONE;
               end else if (ret_c) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == TMO_W'(TIMEOUT-1)) begin
                  err_o      <= 1'b1;
                  err_code_o <= ERR_TIMEOUT;
                  state      <= ST_DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
            end
            ST_DONE: begin
               frame_done_o <= 1'b1;
               busy_o       <= 1'b0;
               state        <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef MRELBP_CI_HIST_EN
   // CI result statistics; held after the frame until the next accepted start.
   always_ff @(posedge clk) begin
      if (rst || start_ok_c) begin
         hist_ones_o  <= '0;
         hist_total_o <= '0;
      end else if (ret_c) begin
         hist_total_o <= hist_total_o + CNT_W'(1);
         if (ci_bit_i) hist_ones_o <= hist_ones_o + CNT_W'(1);
      end
   end
`endif

endmodule
